// File: rtl/dbg_memi_master_if.sv
// Command, memi and response signals of the debug memi master, grouped as one bundle.
// Latency: none; this is wiring only.
// Backpressure: cmd_valid/cmd_ready on the command side, rsp_valid/rsp_ready on the response side.
interface dbg_memi_master_if #(
    parameter int NR_SLAVES  = 1,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
);
    localparam int SLAVE_WIDTH = (NR_SLAVES > 1) ? $clog2(NR_SLAVES) : 1;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [SLAVE_WIDTH-1:0] cmd_slave;
    logic [ADDR_WIDTH-1:0]  cmd_addr;
    logic [DATA_WIDTH-1:0]  cmd_wdata;
    logic [LEN_WIDTH-1:0]   cmd_len;
    logic                   cmd_autoinc;

    logic [ADDR_WIDTH-1:0]  memi_addr;
    logic [NR_SLAVES-1:0]   memi_sel;
    logic                   memi_wr_rd;
    logic [DATA_WIDTH-1:0]  memi_wdata;
    logic [DATA_WIDTH-1:0]  memi_rdata;
    logic                   memi_ack;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_WIDTH-1:0]  rsp_rdata;
    logic                   rsp_err;
    logic                   busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_slave, cmd_addr, cmd_wdata, cmd_len, cmd_autoinc,
        output cmd_ready,
        output memi_addr, memi_sel, memi_wr_rd, memi_wdata,
        input  memi_rdata, memi_ack,
        output rsp_valid, rsp_rdata, rsp_err, busy,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_slave, cmd_addr, cmd_wdata, cmd_len, cmd_autoinc,
        input  cmd_ready,
        input  memi_addr, memi_sel, memi_wr_rd, memi_wdata,
        output memi_rdata, memi_ack,
        input  rsp_valid, rsp_rdata, rsp_err, busy,
        output rsp_ready
    );
endinterface

// File: rtl/dbg_memi_master.sv
// Debug memi master: queues burst commands and runs them beat by beat on the memi bus.
// Latency: command accepted in N -> memi_sel in N+2 (idle, empty FIFO); memi_ack in M -> rsp_valid in M+1.
// Backpressure: cmd_ready drops while the FIFO is full; the FSM parks in RESP until rsp_ready.
module dbg_memi_master #(
    parameter int NR_SLAVES  = 1,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic               memi_clk,
    input  logic               memi_rst,
    dbg_memi_master_if.master  bus
);
    localparam int SW = (NR_SLAVES > 1) ? $clog2(NR_SLAVES) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic                  write;
        logic [SW-1:0]         slave;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [LEN_WIDTH-1:0]  len;
        logic                  autoinc;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE_CHK} state_t;

    // An out-of-range slave index maps to an all-zero select.
    function automatic logic [NR_SLAVES-1:0] onehot(input logic [SW-1:0] s);
        onehot = '0;
        if (int'(s) < NR_SLAVES)
            onehot = NR_SLAVES'(1) << s;
    endfunction

    // ---------------- command FIFO ----------------
    cmd_t           mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           full, empty, push, pop;
    cmd_t           in_cmd, head;
    state_t         state, state_d;

    assign full          = (count == CW'(FIFO_DEPTH));
    assign empty         = (count == '0);
    assign bus.cmd_ready = !memi_rst && !full;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state == IDLE) && !empty;
    assign head          = mem[rd_ptr];
    assign in_cmd        = '{write: bus.cmd_write, slave: bus.cmd_slave, addr: bus.cmd_addr,
                             wdata: bus.cmd_wdata, len: bus.cmd_len, autoinc: bus.cmd_autoinc};

    // Storage array: written on every accepted command, no reset needed.
    always_ff @(posedge memi_clk) begin
        if (push)
            mem[wr_ptr] <= in_cmd;
    end

    // Pointers wrap naturally; the count tells full from empty.
    always_ff @(posedge memi_clk) begin
        if (memi_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- burst engine ----------------
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NR_SLAVES-1:0]  sel_q, sel_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         slave_q, slave_d;
    logic [LEN_WIDTH-1:0]  beats_q, beats_d;
    logic                  autoinc_q, autoinc_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic                  rsp_vld_q, rsp_vld_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  leave;

    assign bus.memi_addr  = addr_q;
    assign bus.memi_sel   = sel_q;
    assign bus.memi_wr_rd = wr_q;
    assign bus.memi_wdata = wdata_q;
    assign bus.rsp_valid  = rsp_vld_q;
    assign bus.rsp_rdata  = rdata_q;
    assign bus.rsp_err    = err_q;
    assign bus.busy       = (state != IDLE) || !empty;

    // Next state and next register values; bus outputs are all registered.
    always_comb begin
        state_d   = state;
        addr_d    = addr_q;
        sel_d     = sel_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        slave_d   = slave_q;
        beats_d   = beats_q;
        autoinc_d = autoinc_q;
        tcnt_d    = tcnt_q;
        rsp_vld_d = rsp_vld_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        leave     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    addr_d    = head.addr;
                    beats_d   = head.len;
                    wr_d      = head.write;
                    slave_d   = head.slave;
                    wdata_d   = head.wdata;
                    autoinc_d = head.autoinc;
                    sel_d     = onehot(head.slave);
                    tcnt_d    = '0;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                tcnt_d = tcnt_q + TW'(1);
                // A zero select means the slave index was out of range.
                if (sel_q == '0) begin
                    leave   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (bus.memi_ack) begin
                    leave   = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = wr_q ? '0 : bus.memi_rdata;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    leave   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
                if (leave) begin
                    sel_d     = '0;
                    rsp_vld_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_vld_d = 1'b0;
                    state_d   = DONE_CHK;
                end
            end
            DONE_CHK: begin
                if (beats_q == '0) begin
                    state_d = IDLE;
                end else begin
                    beats_d = beats_q - LEN_WIDTH'(1);
                    if (autoinc_q)
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    sel_d   = onehot(slave_q);
                    tcnt_d  = '0;
                    state_d = ACCESS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge memi_clk) begin
        if (memi_rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            sel_q     <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            slave_q   <= '0;
            beats_q   <= '0;
            autoinc_q <= 1'b0;
            tcnt_q    <= '0;
            rsp_vld_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            slave_q   <= slave_d;
            beats_q   <= beats_d;
            autoinc_q <= autoinc_d;
            tcnt_q    <= tcnt_d;
            rsp_vld_q <= rsp_vld_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: doc/dbg_memi_master.md
DBG_MEMI_MASTER -- requirements
Module: dbg_memi_master

Interface
REQ-001 Parameter NR_SLAVES, default 1, number of memi slaves; memi_sel is one-hot over them.
REQ-002 Parameter ADDR_WIDTH, default 5, memi address width.
REQ-003 Parameter DATA_WIDTH, default 32, read and write data width.
REQ-004 Parameter FIFO_DEPTH, default 4, command FIFO entries; power of two, at least 2.
REQ-005 Parameter LEN_WIDTH, default 4, burst length field width; beats = cmd_len+1.
REQ-006 Parameter TIMEOUT, default 15, maximum wait cycles for memi_ack; at least 1.
REQ-007 memi_clk  in  1  sole clock; all logic on its rising edge.
REQ-008 memi_rst  in  1  synchronous reset, active-high.
REQ-009 cmd_valid  in  1  command offered.
REQ-010 cmd_ready  out  1  FIFO can accept a command.
REQ-011 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-012 cmd_slave  in  $clog2(NR_SLAVES) (minimum 1)  target slave index.
REQ-013 cmd_addr  in  ADDR_WIDTH  start address.
REQ-014 cmd_wdata  in  DATA_WIDTH  write data; the same value is used for every beat.
REQ-015 cmd_len  in  LEN_WIDTH  beats minus one.
REQ-016 cmd_autoinc  in  1  increment the address after each beat.
REQ-017 memi_addr / memi_sel / memi_wr_rd / memi_wdata  out  ADDR_WIDTH / NR_SLAVES / 1 / DATA_WIDTH  memi master outputs, all registered.
REQ-018 memi_rdata  in  DATA_WIDTH  read data, valid when memi_ack=1.
REQ-019 memi_ack  in  1  slave completion of the current beat.
REQ-020 rsp_valid / rsp_ready  out / in  1 / 1  per-beat response handshake.
REQ-021 rsp_rdata / rsp_err  out  DATA_WIDTH / 1  read data (0 for writes and errors); error flag.
REQ-022 busy  out  1  FSM not in IDLE or FIFO non-empty.

Function
REQ-023 Command FIFO: a command is pushed when cmd_valid & cmd_ready; cmd_ready = !full; a command presented while full is not accepted and shall be held by the source.
REQ-024 FIFO state: pointers wrap modulo FIFO_DEPTH; an occupancy count of 0..FIFO_DEPTH distinguishes full from empty.
REQ-025 Simultaneous push and pop while full: the push is refused (cmd_ready=0) and the pop proceeds.
REQ-026 Simultaneous push and pop at any other occupancy: the count is unchanged.
REQ-027 FSM states: IDLE, ACCESS, RESP, DONE_CHK.
REQ-028 IDLE: if the FIFO is non-empty, pop the head into working registers (addr, beat counter = cmd_len, write, slave, wdata, autoinc) and go to ACCESS.
REQ-029 ACCESS: memi_sel = one-hot(slave), plus memi_addr, memi_wr_rd = write and memi_wdata, held stable until leaving ACCESS.
REQ-030 ACCESS exit on memi_ack=1: capture memi_rdata (reads) and set err=0.
REQ-031 ACCESS exit on timeout: after TIMEOUT cycles in ACCESS without ack, set err=1 and rdata=0; the timeout counter clears on ACCESS entry.
REQ-032 ACCESS with slave >= NR_SLAVES: memi_sel = 0 and exit after 1 cycle with err=1.
REQ-033 On any ACCESS exit, drive memi_sel=0 and go to RESP.
REQ-034 Latency: command handshake in cycle N gives FIFO non-empty in N+1, IDLE pop in N+1, and memi_sel asserted in N+2 (FIFO previously empty, FSM in IDLE).
REQ-035 Latency: ack in cycle M gives rsp_valid=1 in M+1.
REQ-036 RESP: rsp_valid=1 with rsp_rdata and rsp_err held stable until rsp_ready=1; leave on the handshake.
REQ-037 Back-pressure: rsp_valid shall not drop without a handshake.
REQ-038 DONE_CHK: if beat counter = 0, go to IDLE.
REQ-039 DONE_CHK otherwise: decrement the counter; if autoinc, addr = addr+1 modulo 2^ADDR_WIDTH (wraps from all-ones to 0); then go to ACCESS.
REQ-040 An error on one beat does not abort the burst; every beat yields exactly one response.
REQ-041 memi_ack outside ACCESS is ignored.
REQ-042 Responses are produced in command order.

Reset
REQ-043 With memi_rst=1 at a clock edge: FSM=IDLE, FIFO emptied, cmd_ready=0 during reset and 1 on the first cycle after release.
REQ-044 Reset values: memi_sel=0, memi_addr=0, memi_wr_rd=0, memi_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
REQ-045 Reset mid-burst or mid-RESP shall abandon the burst with no further memi access or response.

Verification
REQ-046 Single read: slave 0, addr 5, len 0; ack with rdata 0xDEADBEEF on the 3rd ACCESS cycle -> one response, rdata 0xDEADBEEF, err 0; memi_sel up 2 cycles after the handshake.
REQ-047 Write burst: addr 0x1E, len 3, autoinc 1, immediate ack -> memi_addr sequence 0x1E, 0x1F, 0x00, 0x01 with wr_rd=1 and fixed wdata; 4 responses with err 0.
REQ-048 Timeout: never ack, TIMEOUT=15 -> sel held exactly 15 cycles; response err=1, rdata=0.
REQ-049 Bad slave: NR_SLAVES=3, cmd_slave=3 -> memi_sel stays 0; response err=1.
REQ-050 Full FIFO: push 5 commands with the FSM stalled in RESP (rsp_ready=0) -> cmd_ready=0 after the 4th FIFO entry; all responses delivered in order once rsp_ready=1.
REQ-051 Reset during the 2nd beat of a len=3 burst -> outputs at reset values next cycle; no further responses; cmd_ready=1 after release.
